hls_activity_monitor: RTL and testbench

- Synthesizable, non-intrusive performance monitor for one HLS-generated top function.
- Observes three things, all on a single clock, and exposes them as counters for a host or testbench to read:
  - the top module's ap_start/ap_ready/ap_done handshake;
  - one FSM-sequenced (non-pipelined) loop, via its one-hot state register;
  - one pipelined loop (UPC style), via its stage, enable and block signals.
- Sits beside the DUT and only reads its signals. It never drives the DUT.

---
 rtl/hls_activity_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_hls_activity_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_activity_monitor.sv
// Passive performance monitor for one HLS top function: module handshake,
// one FSM-sequenced loop and one pipelined loop. Optional macro: UPC_STALL_CNT_EN.
module hls_activity_monitor #(
  parameter int SEQ_STATE_W = 5,
  parameter int UPC_STATE_W = 2,
  parameter int CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   finish,
  input  logic                   mod_start,
  input  logic                   mod_ready,
  input  logic                   mod_done,
  input  logic                   mod_continue,
  input  logic [SEQ_STATE_W-1:0] seq_cur_state,
  input  logic [SEQ_STATE_W-1:0] seq_pre_state,
  input  logic [SEQ_STATE_W-1:0] seq_post_state,
  input  logic [SEQ_STATE_W-1:0] seq_quit_state,
  input  logic [SEQ_STATE_W-1:0] seq_iter_start_state,
  input  logic [SEQ_STATE_W-1:0] seq_iter_end_state,
  input  logic [UPC_STATE_W-1:0] upc_cur_state,
  input  logic [UPC_STATE_W-1:0] upc_iter_start_state,
  input  logic [UPC_STATE_W-1:0] upc_iter_end_state,
  input  logic [UPC_STATE_W-1:0] upc_quit_state,
  input  logic                   upc_iter_start_block,
  input  logic                   upc_iter_end_block,
  input  logic                   upc_quit_block,
  input  logic                   upc_iter_start_enable,
  input  logic                   upc_iter_end_enable,
  input  logic                   upc_quit_enable,
  input  logic                   upc_loop_start,
  input  logic                   upc_loop_done,
  output logic                   mod_busy,
  output logic [CNT_W-1:0]       mod_txn_cnt,
  output logic [CNT_W-1:0]       mod_last_lat,
  output logic                   seq_active,
  output logic [CNT_W-1:0]       seq_iter_cnt,
  output logic [CNT_W-1:0]       seq_trip_cnt,
  output logic                   upc_active,
  output logic [CNT_W-1:0]       upc_iter_start_cnt,
  output logic [CNT_W-1:0]       upc_iter_end_cnt,
  output logic [CNT_W-1:0]       upc_inv_cnt,
  output logic [CNT_W-1:0]       upc_last_cycles
`ifdef UPC_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]       upc_stall_cnt
`endif
);

  typedef enum logic {
    MOD_IDLE = 1'b0,
    MOD_BUSY = 1'b1
  } mod_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_ONE;
  endfunction

  // mod_ready is observed but deliberately influences nothing.
  logic unused_inputs;
  assign unused_inputs = ^{mod_ready, upc_quit_state, upc_quit_block, upc_quit_enable};

  // ---------------------------------------------------------------------------
  // Module handshake monitor
  // ---------------------------------------------------------------------------
  mod_state_t       mod_state;
  logic [CNT_W-1:0] mod_lat;
  logic             mod_end;

  assign mod_end  = mod_done && mod_continue;
  assign mod_busy = (mod_state == MOD_BUSY);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      mod_state    <= MOD_IDLE;
      mod_lat      <= '0;
      mod_txn_cnt  <= '0;
      mod_last_lat <= '0;
    end else if (!finish) begin
      case (mod_state)
        MOD_IDLE: begin
          if (mod_start) begin
            mod_state <= MOD_BUSY;
            mod_lat   <= CNT_ONE;
          end
        end
        MOD_BUSY: begin
          if (mod_end) begin
            // The done cycle itself belongs to the transaction's latency.
            mod_txn_cnt  <= sat_inc(mod_txn_cnt);
            mod_last_lat <= sat_inc(mod_lat);
            if (mod_start) begin
              mod_lat <= CNT_ONE;
            end else begin
              mod_state <= MOD_IDLE;
              mod_lat   <= '0;
            end
          end else begin
            mod_lat <= sat_inc(mod_lat);
          end
        end
        default: begin
          mod_state <= MOD_IDLE;
          mod_lat   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequenced (FSM) loop monitor
  // ---------------------------------------------------------------------------
  logic [SEQ_STATE_W-1:0] seq_prev;
  logic                   seq_entry;
  logic                   seq_iter_done;
  logic                   seq_exit;

  assign seq_entry     = (seq_prev == seq_pre_state) && (seq_cur_state == seq_iter_start_state);
  assign seq_iter_done = seq_active && (seq_prev == seq_iter_end_state)
                         && (seq_cur_state != seq_iter_end_state);
  assign seq_exit      = seq_active && (seq_prev == seq_quit_state)
                         && (seq_cur_state == seq_post_state);

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_prev     <= '0;
      seq_active   <= 1'b0;
      seq_iter_cnt <= '0;
      seq_trip_cnt <= '0;
    end else if (!finish) begin
      seq_prev <= seq_cur_state;
      if (seq_iter_done) begin
        seq_iter_cnt <= sat_inc(seq_iter_cnt);
      end
      if (seq_exit) begin
        seq_trip_cnt <= sat_inc(seq_trip_cnt);
      end
      // Entry wins so an exit/entry pair through a shared pre/post state re-arms.
      if (seq_entry) begin
        seq_active <= 1'b1;
      end else if (seq_exit) begin
        seq_active <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipelined (UPC) loop monitor
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] upc_cycles;
  logic             upc_issue;
  logic             upc_retire;

  assign upc_issue  = (upc_cur_state == upc_iter_start_state) && upc_iter_start_enable
                      && !upc_iter_start_block;
  assign upc_retire = (upc_cur_state == upc_iter_end_state) && upc_iter_end_enable
                      && !upc_iter_end_block;

  always_ff @(posedge clock) begin
    if (reset) begin
      upc_active         <= 1'b0;
      upc_cycles         <= '0;
      upc_iter_start_cnt <= '0;
      upc_iter_end_cnt   <= '0;
      upc_inv_cnt        <= '0;
      upc_last_cycles    <= '0;
    end else if (!finish) begin
      if (upc_issue) begin
        upc_iter_start_cnt <= sat_inc(upc_iter_start_cnt);
      end
      if (upc_retire) begin
        upc_iter_end_cnt <= sat_inc(upc_iter_end_cnt);
      end
      if (!upc_active) begin
        if (upc_loop_start) begin
          upc_active <= 1'b1;
          upc_cycles <= CNT_ONE;
        end
      end else if (upc_loop_done) begin
        upc_active      <= 1'b0;
        upc_inv_cnt     <= sat_inc(upc_inv_cnt);
        upc_last_cycles <= sat_inc(upc_cycles);
        upc_cycles      <= '0;
      end else begin
        upc_cycles <= sat_inc(upc_cycles);
      end
    end
  end

`ifdef UPC_STALL_CNT_EN
  logic upc_stall;

  assign upc_stall = upc_active &&
                     (((upc_cur_state == upc_iter_start_state) && upc_iter_start_enable
                       && upc_iter_start_block) ||
                      ((upc_cur_state == upc_quit_state) && upc_quit_enable
                       && upc_quit_block));

  always_ff @(posedge clock) begin
    if (reset) begin
      upc_stall_cnt <= '0;
    end else if (!finish && upc_stall) begin
      upc_stall_cnt <= sat_inc(upc_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hls_activity_monitor.sv
// Directed bench for hls_activity_monitor: a tick-based behavioural model
// compared every cycle, plus literal checkpoints after each scenario.
module tb_hls_activity_monitor;

  localparam int SW = 5;
  localparam int UW = 2;
  localparam int CW = 32;
  localparam longint MAXC = (longint'(1) << CW) - 1;

  logic          clock = 1'b0;
  logic          reset, finish;
  logic          mod_start, mod_ready, mod_done, mod_continue;
  logic [SW-1:0] seq_cur_state, seq_pre_state, seq_post_state, seq_quit_state;
  logic [SW-1:0] seq_iter_start_state, seq_iter_end_state;
  logic [UW-1:0] upc_cur_state, upc_iter_start_state, upc_iter_end_state, upc_quit_state;
  logic          upc_iter_start_block, upc_iter_end_block, upc_quit_block;
  logic          upc_iter_start_enable, upc_iter_end_enable, upc_quit_enable;
  logic          upc_loop_start, upc_loop_done;
  logic          mod_busy, seq_active, upc_active;
  logic [CW-1:0] mod_txn_cnt, mod_last_lat, seq_iter_cnt, seq_trip_cnt;
  logic [CW-1:0] upc_iter_start_cnt, upc_iter_end_cnt, upc_inv_cnt, upc_last_cycles;
`ifdef UPC_STALL_CNT_EN
  logic [CW-1:0] upc_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  hls_activity_monitor #(.SEQ_STATE_W(SW), .UPC_STATE_W(UW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .mod_start(mod_start), .mod_ready(mod_ready), .mod_done(mod_done),
    .mod_continue(mod_continue),
    .seq_cur_state(seq_cur_state), .seq_pre_state(seq_pre_state),
    .seq_post_state(seq_post_state), .seq_quit_state(seq_quit_state),
    .seq_iter_start_state(seq_iter_start_state), .seq_iter_end_state(seq_iter_end_state),
    .upc_cur_state(upc_cur_state), .upc_iter_start_state(upc_iter_start_state),
    .upc_iter_end_state(upc_iter_end_state), .upc_quit_state(upc_quit_state),
    .upc_iter_start_block(upc_iter_start_block), .upc_iter_end_block(upc_iter_end_block),
    .upc_quit_block(upc_quit_block),
    .upc_iter_start_enable(upc_iter_start_enable), .upc_iter_end_enable(upc_iter_end_enable),
    .upc_quit_enable(upc_quit_enable),
    .upc_loop_start(upc_loop_start), .upc_loop_done(upc_loop_done),
    .mod_busy(mod_busy), .mod_txn_cnt(mod_txn_cnt), .mod_last_lat(mod_last_lat),
    .seq_active(seq_active), .seq_iter_cnt(seq_iter_cnt), .seq_trip_cnt(seq_trip_cnt),
    .upc_active(upc_active), .upc_iter_start_cnt(upc_iter_start_cnt),
    .upc_iter_end_cnt(upc_iter_end_cnt), .upc_inv_cnt(upc_inv_cnt),
    .upc_last_cycles(upc_last_cycles)
`ifdef UPC_STALL_CNT_EN
    , .upc_stall_cnt(upc_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Model: latencies are differences of a run-time tick that only advances
  // on edges that are neither reset nor frozen.
  longint m_tick;
  bit     m_mod_busy, m_seq_act, m_upc_act;
  longint m_mod_t0, m_mod_txn, m_mod_last;
  longint m_seq_prev, m_seq_iter, m_seq_trip;
  longint m_upc_t0, m_upc_s, m_upc_e, m_upc_inv, m_upc_last, m_stall;

  always @(posedge clock) begin
    if (reset) begin
      m_tick = 0; m_mod_busy = 0; m_seq_act = 0; m_upc_act = 0;
      m_mod_t0 = 0; m_mod_txn = 0; m_mod_last = 0;
      m_seq_prev = 0; m_seq_iter = 0; m_seq_trip = 0;
      m_upc_t0 = 0; m_upc_s = 0; m_upc_e = 0; m_upc_inv = 0; m_upc_last = 0; m_stall = 0;
    end else if (!finish) begin
      bit entry, iter_done, leave, was_upc;
      m_tick++;
      if (!m_mod_busy) begin
        if (mod_start) begin m_mod_busy = 1; m_mod_t0 = m_tick; end
      end else if (mod_done && mod_continue) begin
        m_mod_txn  = sat(m_mod_txn + 1);
        m_mod_last = sat(m_tick - m_mod_t0 + 1);
        m_mod_busy = mod_start;
        m_mod_t0   = m_tick;
      end
      entry     = (m_seq_prev == seq_pre_state) && (seq_cur_state == seq_iter_start_state);
      iter_done = m_seq_act && (m_seq_prev == seq_iter_end_state) &&
                  (seq_cur_state != seq_iter_end_state);
      leave     = m_seq_act && (m_seq_prev == seq_quit_state) && (seq_cur_state == seq_post_state);
      if (iter_done) m_seq_iter = sat(m_seq_iter + 1);
      if (leave) m_seq_trip = sat(m_seq_trip + 1);
      if (entry) m_seq_act = 1; else if (leave) m_seq_act = 0;
      m_seq_prev = seq_cur_state;
      was_upc = m_upc_act;
`ifdef UPC_STALL_CNT_EN
      if (was_upc && (((upc_cur_state == upc_iter_start_state) && upc_iter_start_enable &&
                       upc_iter_start_block) ||
                      ((upc_cur_state == upc_quit_state) && upc_quit_enable && upc_quit_block)))
        m_stall = sat(m_stall + 1);
`endif
      if ((upc_cur_state == upc_iter_start_state) && upc_iter_start_enable && !upc_iter_start_block)
        m_upc_s = sat(m_upc_s + 1);
      if ((upc_cur_state == upc_iter_end_state) && upc_iter_end_enable && !upc_iter_end_block)
        m_upc_e = sat(m_upc_e + 1);
      if (!was_upc && upc_loop_start) begin
        m_upc_act = 1; m_upc_t0 = m_tick;
      end else if (was_upc && upc_loop_done) begin
        m_upc_act = 0; m_upc_inv = sat(m_upc_inv + 1); m_upc_last = sat(m_tick - m_upc_t0 + 1);
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("mod_busy", mod_busy, m_mod_busy);
      check("mod_txn_cnt", mod_txn_cnt, m_mod_txn);
      check("mod_last_lat", mod_last_lat, m_mod_last);
      check("seq_active", seq_active, m_seq_act);
      check("seq_iter_cnt", seq_iter_cnt, m_seq_iter);
      check("seq_trip_cnt", seq_trip_cnt, m_seq_trip);
      check("upc_active", upc_active, m_upc_act);
      check("upc_iter_start_cnt", upc_iter_start_cnt, m_upc_s);
      check("upc_iter_end_cnt", upc_iter_end_cnt, m_upc_e);
      check("upc_inv_cnt", upc_inv_cnt, m_upc_inv);
      check("upc_last_cycles", upc_last_cycles, m_upc_last);
`ifdef UPC_STALL_CNT_EN
      check("upc_stall_cnt", upc_stall_cnt, m_stall);
`endif
    end
  end

  // Each call advances n rising edges; inputs set before the call are sampled.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  int seq_a[15] = '{1, 2, 4, 8, 16, 2, 4, 8, 16, 2, 4, 8, 16, 2, 1};
  int seq_b[8]  = '{2, 1, 2, 4, 8, 16, 2, 1};

  initial begin
    reset = 1; finish = 0;
    mod_start = 0; mod_ready = 0; mod_done = 0; mod_continue = 0;
    seq_cur_state = '0;
    seq_pre_state = SW'(1); seq_post_state = SW'(1); seq_quit_state = SW'(2);
    seq_iter_start_state = SW'(2); seq_iter_end_state = SW'(16);
    upc_cur_state = 2'b01; upc_iter_start_state = 2'b01; upc_iter_end_state = 2'b01;
    upc_quit_state = 2'b10;
    upc_iter_start_block = 0; upc_iter_end_block = 0; upc_quit_block = 0;
    upc_iter_start_enable = 0; upc_iter_end_enable = 0; upc_quit_enable = 0;
    upc_loop_start = 0; upc_loop_done = 0;
    cyc(2);
    cmp_en = 1;
    reset = 0;

    // Idle after reset
    cyc(10);
    check("idle mod_busy", mod_busy, 0);
    check("idle mod_txn_cnt", mod_txn_cnt, 0);
    check("idle upc_active", upc_active, 0);
    check("idle seq_trip_cnt", seq_trip_cnt, 0);

    // Module: start at cycle 0, done without continue at 5, done at 9
    mod_start = 1; cyc(1);
    mod_start = 0; cyc(4);
    mod_done = 1; mod_ready = 1; cyc(1);
    mod_done = 0; mod_ready = 0; cyc(3);
    check("mod busy before done", mod_busy, 1);
    mod_done = 1; mod_continue = 1; cyc(1);
    mod_done = 0; mod_continue = 0;
    check("mod txn 1", mod_txn_cnt, 1);
    check("mod lat 10", mod_last_lat, 10);
    check("model mod lat 10", m_mod_last, 10);
    check("mod idle after done", mod_busy, 0);

    // Back-to-back: done+start at cycle 4 (lat 5), then done 2 cycles later (lat 3)
    mod_start = 1; cyc(1);
    mod_start = 0; cyc(3);
    mod_done = 1; mod_continue = 1; mod_start = 1; cyc(1);
    check("b2b lat 5", mod_last_lat, 5);
    check("b2b still busy", mod_busy, 1);
    mod_done = 0; mod_continue = 0; mod_start = 0; cyc(1);
    mod_done = 1; mod_continue = 1; cyc(1);
    mod_done = 0; mod_continue = 0;
    check("b2b txn 3", mod_txn_cnt, 3);
    check("b2b lat 3", mod_last_lat, 3);

    // Sequenced loop: 3 iterations, then zero-trip plus immediate re-entry
    foreach (seq_a[i]) begin seq_cur_state = SW'(seq_a[i]); cyc(1); end
    check("seq iter 3", seq_iter_cnt, 3);
    check("seq trip 1", seq_trip_cnt, 1);
    check("seq inactive", seq_active, 0);
    foreach (seq_b[i]) begin seq_cur_state = SW'(seq_b[i]); cyc(1); end
    check("seq iter 4", seq_iter_cnt, 4);
    check("seq trip 3", seq_trip_cnt, 3);
    check("model seq trip 3", m_seq_trip, 3);

    // Pipelined loop: start at 0, 8 issues/retires, done in 10th cycle
    upc_loop_start = 1; cyc(1);
    upc_loop_start = 0; upc_iter_start_enable = 1; upc_iter_end_enable = 1; cyc(8);
    upc_iter_start_enable = 0; upc_iter_end_enable = 0; upc_loop_done = 1; cyc(1);
    upc_loop_done = 0;
    check("upc issues 8", upc_iter_start_cnt, 8);
    check("upc retires 8", upc_iter_end_cnt, 8);
    check("upc inv 1", upc_inv_cnt, 1);
    check("upc cycles 10", upc_last_cycles, 10);
    check("model upc cycles 10", m_upc_last, 10);
    check("upc inactive", upc_active, 0);

    // Reset mid-transaction and mid-invocation
    reset = 1; cyc(1); reset = 0;
    mod_start = 1; upc_loop_start = 1; cyc(1);
    mod_start = 0; upc_loop_start = 0; cyc(3);
    reset = 1; cyc(1); reset = 0;
    check("rst mod_busy", mod_busy, 0);
    check("rst upc_active", upc_active, 0);
    mod_done = 1; mod_continue = 1; upc_loop_done = 1; cyc(1);
    mod_done = 0; mod_continue = 0; upc_loop_done = 0;
    check("rst txn 0", mod_txn_cnt, 0);
    check("rst inv 0", upc_inv_cnt, 0);

    // Freeze with everything active
    seq_cur_state = SW'(1); mod_start = 1; upc_loop_start = 1; cyc(1);
    mod_start = 0; upc_loop_start = 0; seq_cur_state = SW'(2); upc_iter_start_enable = 1; cyc(2);
    finish = 1; seq_cur_state = SW'(4); mod_done = 1; mod_continue = 1; upc_loop_done = 1; cyc(4);
    check("frz mod_busy", mod_busy, 1);
    check("frz txn", mod_txn_cnt, 0);
    check("frz issues", upc_iter_start_cnt, 2);
    check("frz upc_active", upc_active, 1);
    check("frz seq_active", seq_active, 1);
    finish = 0; seq_cur_state = SW'(2); mod_done = 0; mod_continue = 0; upc_loop_done = 0;
    upc_iter_start_enable = 0; cyc(1);
    mod_done = 1; mod_continue = 1; upc_loop_done = 1; cyc(1);
    mod_done = 0; mod_continue = 0; upc_loop_done = 0;
    check("frz mod lat 5", mod_last_lat, 5);
    check("frz upc cycles 5", upc_last_cycles, 5);
    foreach (seq_a[i]) if (i >= 10) begin seq_cur_state = SW'(seq_a[i]); cyc(1); end
    check("frz seq iter 1", seq_iter_cnt, 1);
    check("frz seq trip 1", seq_trip_cnt, 1);

`ifdef UPC_STALL_CNT_EN
    upc_loop_start = 1; cyc(1);
    upc_loop_start = 0; upc_iter_start_enable = 1; upc_iter_start_block = 1; cyc(3);
    upc_iter_start_enable = 0; upc_iter_start_block = 0; upc_loop_done = 1; cyc(1);
    upc_loop_done = 0;
    check("stall 3", upc_stall_cnt, 3);
    upc_cur_state = 2'b10; upc_quit_enable = 1; upc_quit_block = 1; cyc(2);
    upc_quit_enable = 0; upc_quit_block = 0;
    check("stall idle 3", upc_stall_cnt, 3);
`endif

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
